mips_icache: RTL and testbench
==============================

# mips_icache

Direct-mapped, read-only instruction cache that services the instruction-fetch stage's cache request port and refills from main memory one 4-word block at a time. It sits between the IF stage (`I_read`/`I_addr`/`I_rdata`) and the external memory bus. It returns hits combinationally. On a miss it holds the pipeline with `proc_stall` until the refill completes.

## Interface
- `LINES`, default 8: number of cache lines; power of two, 2..256. `IDX_W = log2(LINES)`, `TAG_W = 28 - IDX_W`.
- `clk`  in  1  single clock, all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `proc_read`  in  1  fetch request (IF `I_read`).
- `proc_write`  in  1  IF `I_write`; ignored, no state effect.
- `proc_addr`  in  30  word address (IF `I_addr`): [29:2+IDX_W] tag, [1+IDX_W:2] index, [1:0] word offset.
- `proc_wdata`  in  32  ignored.
- `proc_rdata`  out  32  fetched instruction (to IF `I_rdata`).
- `proc_stall`  out  1  request not satisfied this cycle; pipeline must hold.
- `mem_read`  out  1  block read request to memory.
- `mem_write`  out  1  tied 0.
- `mem_addr`  out  28  block address `{tag,index}`.
- `mem_wdata`  out  128  tied 0.
- `mem_rdata`  in  128  refill block; word 0 in [31:0], word 3 in [127:96].
- `mem_ready`  in  1  `mem_rdata` valid, completes the current request.

## Operation
- Storage: per line, a valid bit, a `TAG_W` tag, and 128 data bits. Only valid bits and control state are reset. Tag and data arrays are not reset.
- Hit is `proc_read & valid[index] & (tag[index] == addr tag)`, evaluated only in IDLE.
- `proc_rdata` is the selected word on a hit, otherwise 32'h0. A 0 fetch is a MIPS NOP, so the IF mini-decoder sees no branch while stalled.
- `proc_stall` is `proc_read & ~hit` in IDLE, and 1 in REFILL and FILL. It is 0 whenever `proc_read` is 0 in IDLE.
- FSM:
  - IDLE: on a miss, latch `mem_addr = proc_addr[29:2]` and go to REFILL.
  - REFILL: `mem_read = 1` with `mem_addr` held. When `mem_ready` is sampled 1, write `mem_rdata` into the line selected by the latched index, write the latched tag, set valid, and go to FILL.
  - FILL: one cycle with no memory request, then go to IDLE. The re-lookup in IDLE then hits.
- `mem_read` and `mem_addr` are registered outputs. `mem_read` is 0 in IDLE and FILL.
- `proc_addr` must be stable while `proc_stall = 1`. If it changes anyway, the refill still completes for the latched block, and the new address is looked up on return to IDLE. This may cause a second miss.
- `mem_ready` outside REFILL is ignored.
- A refill replaces the resident line unconditionally. No write-back is ever needed.
- Reset asserted mid-refill: `mem_read` drops immediately (asynchronous), all valid bits clear, and the FSM returns to IDLE. The memory side must tolerate an abandoned request.

## Timing
- Reset values: state IDLE, all valid bits 0, `mem_read` 0, `mem_addr` 0, `mem_write` 0, `mem_wdata` 0. `proc_rdata` is 0 and `proc_stall` equals `proc_read`, because every line is invalid.
- Hit: 0-cycle latency; data and `proc_stall = 0` in the same cycle as the request.
- Miss, with the request in cycle 0:
  - Cycle 0: `proc_stall = 1`.
  - Cycle 1: `mem_read = 1`.
  - Cycle 1+L: `mem_ready` arrives after L ≥ 0 wait cycles.
  - Cycle 2+L: FILL.
  - Cycle 3+L: hit, `proc_stall = 0`, data valid.
  - Miss penalty = L + 3 stall cycles.
- Only one outstanding memory request at a time.

## Test plan
- Reset, then `proc_read=1`, `proc_addr=0` → `proc_stall=1`, `proc_rdata=0`. Next cycle `mem_read=1`, `mem_addr=0`.
- Cold miss at `proc_addr=30'h5`, with `mem_ready` after 3 cycles returning {32'hD,32'hC,32'hB,32'hA} (word 3 … word 0) → stall for 6 cycles, then `proc_rdata=32'hB`, `proc_stall=0`. Subsequent addresses 4, 6, 7 hit with 32'hA, 32'hC, 32'hD and no stall.
- Conflict: fill `proc_addr=0`, then `proc_addr=4*LINES` (same index, new tag) → miss with `mem_addr=LINES`. A return to `proc_addr=0` then misses again.
- `mem_ready=1` in the same cycle `mem_read` first rises (L=0) → FILL the next cycle, hit on the cycle after; 3 stall cycles total.
- Assert `rst_n=0` during REFILL → `mem_read=0` immediately. After release, the previously filled address misses.
- `proc_read=0` with `proc_write=1` and random `proc_wdata` for 10 cycles → `proc_stall=0`, `mem_read=0`, and no valid bit changes.

Source files
------------

// File: rtl/mips_icache.sv
// Direct-mapped read-only instruction cache: combinational hits, 4-word block
// refill from memory while the fetch stage is stalled.
module mips_icache #(
    parameter int LINES = 8,
    parameter int IDX_W = $clog2(LINES),
    parameter int TAG_W = 28 - IDX_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         proc_read,
    input  logic         proc_write,
    input  logic [29:0]  proc_addr,
    input  logic [31:0]  proc_wdata,
    output logic [31:0]  proc_rdata,
    output logic         proc_stall,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready
);

    typedef enum logic [1:0] {IDLE, REFILL, FILL} state_t;

    state_t             state_q, state_d;
    logic [LINES-1:0]   valid_q, valid_d;
    logic               mem_read_q, mem_read_d;
    logic [27:0]        mem_addr_q, mem_addr_d;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [127:0]       data_q [LINES];

    logic [IDX_W-1:0]   idx;
    logic [TAG_W-1:0]   tag;
    logic [1:0]         off;
    logic [IDX_W-1:0]   fill_idx;
    logic               hit;
    logic               fill_en;
    logic               unused_inputs;

    assign idx      = proc_addr[1+IDX_W:2];
    assign tag      = proc_addr[29:2+IDX_W];
    assign off      = proc_addr[1:0];
    assign fill_idx = mem_addr_q[IDX_W-1:0];

    // Writes never allocate or modify anything; the write port is inert.
    assign unused_inputs = ^{proc_write, proc_wdata};

    assign hit = (state_q == IDLE) & proc_read & valid_q[idx] & (tag_q[idx] == tag);

    // A miss returns 0 (a NOP) so the fetch-stage decoder never sees a branch.
    assign proc_rdata = hit ? data_q[idx][{off, 5'd0} +: 32] : 32'h0;
    assign proc_stall = (state_q == IDLE) ? (proc_read & ~hit) : 1'b1;

    assign mem_read  = mem_read_q;
    assign mem_addr  = mem_addr_q;
    assign mem_write = 1'b0;
    assign mem_wdata = 128'h0;

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        mem_read_d = mem_read_q;
        mem_addr_d = mem_addr_q;
        fill_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (proc_read && !hit) begin
                    mem_addr_d = proc_addr[29:2];
                    mem_read_d = 1'b1;
                    state_d    = REFILL;
                end
            end
            REFILL: begin
                if (mem_ready) begin
                    fill_en           = 1'b1;
                    valid_d[fill_idx] = 1'b1;
                    mem_read_d        = 1'b0;
                    state_d           = FILL;
                end
            end
            FILL: begin
                state_d = IDLE;
            end
            default: begin
                mem_read_d = 1'b0;
                state_d    = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            mem_read_q <= 1'b0;
            mem_addr_q <= 28'h0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            mem_read_q <= mem_read_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    // Tag and data arrays carry no reset; valid bits guard them.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[fill_idx]  <= mem_addr_q[27:IDX_W];
            data_q[fill_idx] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_mips_icache.sv
// Directed bench for mips_icache: vector table for hit/idle cycles plus
// hand-written miss, conflict and mid-refill reset sequences.
module tb_mips_icache;

    localparam int LINES = 8;

    logic         clk;
    logic         rst_n;
    logic         proc_read;
    logic         proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic [31:0]  proc_rdata;
    logic         proc_stall;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    int n_cmp = 0;
    int n_err = 0;

    mips_icache #(.LINES(LINES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .proc_read  (proc_read),
        .proc_write (proc_write),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_rdata (proc_rdata),
        .proc_stall (proc_stall),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [127:0] BLK0 = 128'h1000_0003_1000_0002_1000_0001_1000_0000;
    localparam logic [127:0] BLK1 = {32'hD, 32'hC, 32'hB, 32'hA};
    localparam logic [127:0] BLK8 = 128'h8000_0003_8000_0002_8000_0001_8000_0000;
    localparam logic [127:0] JUNK = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;

    typedef struct {
        logic        rd;
        logic [29:0] addr;
        logic        stall;
        logic [31:0] rdata;
    } vec_t;

    vec_t vt[7];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called just after a negedge with the cache in IDLE. Issues a read that must
    // miss, answers the refill after lat wait cycles, and checks the whole miss.
    task automatic miss_seq(input logic [29:0] addr, input int lat, input logic [127:0] blk,
                            input logic [27:0] exp_maddr, input logic [31:0] exp_word);
        int stalls;
        proc_read = 1'b1;
        proc_addr = addr;
        #1;
        chk("miss_stall_c0", {127'h0, proc_stall}, 128'h1);
        chk("miss_rdata_c0", {96'h0, proc_rdata}, 128'h0);
        stalls = 0;
        for (int c = 0; c < 40; c++) begin
            if (!proc_stall) break;
            stalls++;
            if (c == 1) begin
                chk("miss_mem_read_c1", {127'h0, mem_read}, 128'h1);
                chk("miss_mem_addr_c1", {100'h0, mem_addr}, {100'h0, exp_maddr});
            end
            if (c == 2 + lat) chk("miss_fill_mem_read", {127'h0, mem_read}, 128'h0);
            mem_ready = (c == 1 + lat);
            mem_rdata = (c == 1 + lat) ? blk : JUNK;
            @(negedge clk);
            #1;
        end
        mem_ready = 1'b0;
        mem_rdata = JUNK;
        chk("miss_stall_cycles", 128'(stalls), 128'(lat + 3));
        chk("miss_hit_rdata", {96'h0, proc_rdata}, {96'h0, exp_word});
        @(negedge clk);
    endtask

    initial begin
        vt[0] = '{1'b1, 30'h4, 1'b0, 32'hA};
        vt[1] = '{1'b1, 30'h6, 1'b0, 32'hC};
        vt[2] = '{1'b1, 30'h7, 1'b0, 32'hD};
        vt[3] = '{1'b1, 30'h5, 1'b0, 32'hB};
        vt[4] = '{1'b1, 30'h2, 1'b0, 32'h1000_0002};
        vt[5] = '{1'b0, 30'h5, 1'b0, 32'h0};
        vt[6] = '{1'b0, 30'h0, 1'b0, 32'h0};

        rst_n      = 1'b0;
        proc_read  = 1'b0;
        proc_write = 1'b0;
        proc_addr  = 30'h0;
        proc_wdata = 32'h0;
        mem_rdata  = JUNK;
        mem_ready  = 1'b0;

        // Reset state
        @(negedge clk);
        #1;
        chk("rst_mem_read",  {127'h0, mem_read}, 128'h0);
        chk("rst_mem_addr",  {100'h0, mem_addr}, 128'h0);
        chk("rst_mem_write", {127'h0, mem_write}, 128'h0);
        chk("rst_mem_wdata", mem_wdata, 128'h0);
        chk("rst_stall_idle", {127'h0, proc_stall}, 128'h0);
        proc_read = 1'b1;
        #1;
        chk("rst_stall_read", {127'h0, proc_stall}, 128'h1);
        chk("rst_rdata",      {96'h0, proc_rdata}, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // First miss at address 0 with zero-wait memory
        miss_seq(30'h0, 0, BLK0, 28'h0, 32'h1000_0000);
        // Cold miss at address 5, memory answers after 3 wait cycles
        miss_seq(30'h5, 3, BLK1, 28'h1, 32'hB);

        // Write-port activity must be inert
        proc_read = 1'b0;
        for (int i = 0; i < 10; i++) begin
            proc_write = 1'b1;
            proc_wdata = $urandom;
            proc_addr  = 30'($urandom);
            #1;
            chk("wr_stall",    {127'h0, proc_stall}, 128'h0);
            chk("wr_mem_read", {127'h0, mem_read}, 128'h0);
            @(negedge clk);
        end
        proc_write = 1'b0;

        // Hits on resident lines and idle cycles
        for (int i = 0; i < 7; i++) begin
            proc_read = vt[i].rd;
            proc_addr = vt[i].addr;
            #1;
            chk($sformatf("vec%0d_stall", i), {127'h0, proc_stall}, {127'h0, vt[i].stall});
            chk($sformatf("vec%0d_rdata", i), {96'h0, proc_rdata}, {96'h0, vt[i].rdata});
            chk($sformatf("vec%0d_mem_read", i), {127'h0, mem_read}, 128'h0);
            @(negedge clk);
        end

        // Conflict on index 0: new tag evicts block 0, which then misses again
        miss_seq(30'(4 * LINES), 1, BLK8, 28'(LINES), 32'h8000_0000);
        miss_seq(30'h0, 2, BLK0, 28'h0, 32'h1000_0000);

        // Reset during refill abandons the request and invalidates everything
        proc_read = 1'b1;
        proc_addr = 30'(4 * LINES + 1);
        @(negedge clk);
        #1;
        chk("rrst_mem_read_before", {127'h0, mem_read}, 128'h1);
        rst_n = 1'b0;
        #1;
        chk("rrst_mem_read_async", {127'h0, mem_read}, 128'h0);
        chk("rrst_mem_addr",       {100'h0, mem_addr}, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        miss_seq(30'h5, 1, BLK1, 28'h1, 32'hB);

        proc_read = 1'b0;
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
